// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Tracks EX/MEM/WB destination registers, raises the ID-stage
//               RAW hazard, drives EXE forwarding selects and counts stalls.
//               Optional macro HAZARD_FORWARDING_EN enables forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  src1,
    input  logic [3:0]  src2,
    input  logic        Two_src,
    input  logic        WB_EN_ID,
    input  logic        MEM_R_EN_ID,
    input  logic [3:0]  Dest_ID,
    input  logic        flush,
    input  logic        mem_stall,
    output logic        hazard,
    output logic [1:0]  fwd_sel_src1,
    output logic [1:0]  fwd_sel_src2,
    output logic [15:0] stall_count
);

    typedef struct packed {
        logic       valid;
        logic       wb_en;
        logic       mem_r;
        logic [3:0] dest;
    } slot_t;

    localparam logic [15:0] c_cnt_max  = 16'hFFFF;
    localparam logic [1:0]  c_sel_rf   = 2'b00;
    localparam logic [1:0]  c_sel_mem  = 2'b01;
    localparam logic [1:0]  c_sel_wb   = 2'b10;

    slot_t       r_ex;
    slot_t       r_mem;
    slot_t       r_wb;
    logic [3:0]  r_ex_src1;
    logic [3:0]  r_ex_src2;
    logic        r_ex_two_src;
    logic [15:0] r_stall_cnt;

    logic        w_hazard_raw;
    logic [1:0]  w_fwd1;
    logic [1:0]  w_fwd2;
    logic        w_unused;

    function automatic logic f_match(input slot_t s, input logic [3:0] r);
        return s.valid & s.wb_en & (s.dest == r);
    endfunction

`ifdef HAZARD_FORWARDING_EN
    // Only a load sitting in EX cannot be forwarded in time.
    assign w_hazard_raw = r_ex.mem_r &
                          (f_match(r_ex, src1) | (Two_src & f_match(r_ex, src2)));

    always_comb begin
        w_fwd1 = c_sel_rf;
        w_fwd2 = c_sel_rf;
        if (rst && r_ex.valid) begin
            if (f_match(r_mem, r_ex_src1))
                w_fwd1 = c_sel_mem;
            else if (f_match(r_wb, r_ex_src1))
                w_fwd1 = c_sel_wb;
            if (r_ex_two_src) begin
                if (f_match(r_mem, r_ex_src2))
                    w_fwd2 = c_sel_mem;
                else if (f_match(r_wb, r_ex_src2))
                    w_fwd2 = c_sel_wb;
            end
        end
    end

    assign w_unused = ^{r_mem.mem_r, r_wb.mem_r};
`else
    // WB never stalls: the register file writes before it is read.
    assign w_hazard_raw = f_match(r_ex, src1) | f_match(r_mem, src1) |
                          (Two_src & (f_match(r_ex, src2) | f_match(r_mem, src2)));

    assign w_fwd1   = c_sel_rf;
    assign w_fwd2   = c_sel_rf;
    assign w_unused = ^{r_ex.mem_r, r_ex_src1, r_ex_src2, r_ex_two_src,
                        r_mem.mem_r, r_wb};
`endif

    assign hazard       = rst & ~flush & w_hazard_raw;
    assign fwd_sel_src1 = w_fwd1;
    assign fwd_sel_src2 = w_fwd2;
    assign stall_count  = rst ? r_stall_cnt : 16'h0000;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ex         <= '0;
            r_mem        <= '0;
            r_wb         <= '0;
            r_ex_src1    <= 4'h0;
            r_ex_src2    <= 4'h0;
            r_ex_two_src <= 1'b0;
            r_stall_cnt  <= 16'h0000;
        end else if (!mem_stall) begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            if (flush || hazard)
                r_ex <= '0;
            else
                r_ex <= '{valid: 1'b1, wb_en: WB_EN_ID, mem_r: MEM_R_EN_ID, dest: Dest_ID};
            r_ex_src1    <= src1;
            r_ex_src2    <= src2;
            r_ex_two_src <= Two_src;
            if (hazard && (r_stall_cnt != c_cnt_max))
                r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

endmodule
`default_nettype wire
